// File: rtl/elixirchip_es1_spu_sel_lt_arbiter.sv
// Shares one pipelined sel_lt unit between NUM_REQ requesters: it grants one request per
// enabled cycle, issues the winner's operands, and routes each result back by its one-hot tag.
module elixirchip_es1_spu_sel_lt_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BITS   = 8,
    parameter int LATENCY     = 1,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cke,
    input  logic [NUM_REQ-1:0]             s_req,
    input  logic [NUM_REQ-1:0]             s_carry,
    input  logic [NUM_REQ-1:0]             s_msb_c,
    input  logic [NUM_REQ-1:0]             s_sign,
    input  logic [NUM_REQ*DATA_BITS-1:0]   s_data0,
    input  logic [NUM_REQ*DATA_BITS-1:0]   s_data1,
    output logic [NUM_REQ-1:0]             s_grant,
    output logic                           op_carry,
    output logic                           op_msb_c,
    output logic                           op_sign,
    output logic [DATA_BITS-1:0]           op_data0,
    output logic [DATA_BITS-1:0]           op_data1,
    output logic                           op_valid,
    output logic                           op_clear,
    input  logic [DATA_BITS-1:0]           op_result,
    output logic [DATA_BITS-1:0]           m_data,
    output logic [NUM_REQ-1:0]             m_valid
);

    localparam int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_BITS-1:0] ptr;
    logic [PTR_BITS-1:0] start;
    logic [PTR_BITS-1:0] sel_idx;
    logic                granted;
    int                  cand;

    // tag_pipe[0] sits beside the issue register; tag_pipe[LATENCY] lines up with op_result
    logic [NUM_REQ-1:0]  tag_pipe [LATENCY:0];

    always_comb begin
        s_grant = '0;
        sel_idx = '0;
        granted = 1'b0;
        cand    = 0;
        start   = (ROUND_ROBIN != 0) ? ptr : '0;
        if (cke) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = int'(start) + k;
                if (cand >= NUM_REQ)
                    cand = cand - NUM_REQ;
                if (!granted && s_req[cand]) begin
                    granted       = 1'b1;
                    sel_idx       = cand[PTR_BITS-1:0];
                    s_grant[cand] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr      <= '0;
            op_carry <= 1'b0;
            op_msb_c <= 1'b0;
            op_sign  <= 1'b0;
            op_data0 <= '0;
            op_data1 <= '0;
            op_valid <= 1'b0;
            op_clear <= 1'b0;
        end else if (cke) begin
            if (granted) begin
                ptr      <= (sel_idx == PTR_BITS'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                op_carry <= s_carry[sel_idx];
                op_msb_c <= s_msb_c[sel_idx];
                op_sign  <= s_sign[sel_idx];
                op_data0 <= s_data0[int'(sel_idx)*DATA_BITS +: DATA_BITS];
                op_data1 <= s_data1[int'(sel_idx)*DATA_BITS +: DATA_BITS];
                op_valid <= 1'b1;
                op_clear <= 1'b0;
            end else begin
                // idle slot: operands hold, the datapath emits its clear value
                op_valid <= 1'b0;
                op_clear <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= LATENCY; i++)
                tag_pipe[i] <= '0;
            m_data  <= '0;
            m_valid <= '0;
        end else if (cke) begin
            tag_pipe[0] <= s_grant;
            for (int i = 1; i <= LATENCY; i++)
                tag_pipe[i] <= tag_pipe[i-1];
            m_data  <= op_result;
            m_valid <= tag_pipe[LATENCY];
        end
    end

endmodule
